cpu_pause_ctrl: RTL and testbench
=================================

CPU_PAUSE_CTRL -- requirements
Module: cpu_pause_ctrl

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 64: maximum number of forwarded CPU clock-enable pulses spent waiting for a bus-idle boundary (range 1..255).
REQ-002 Parameter SYNC_RESUME, default 1: 1 = resume only at a vblank rising edge; 0 = resume immediately.
REQ-003 Parameter FW, default 16: width of the paused-frame counter.
REQ-004 clk_sys  in  1  core system clock; the single clock of the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pause_cpu  in  1  pause request from the pause block (active-high, synchronous to clk_sys).
REQ-007 cpu_ce_in  in  1  raw CPU clock-enable pulse train.
REQ-008 cpu_bus_idle  in  1  high when the CPU is at an instruction/bus-cycle boundary.
REQ-009 vblank  in  1  vertical blank from the video timing (active-high).
REQ-010 cpu_ce_out  out  1  gated CPU clock enable.
REQ-011 pause_ack  out  1  CPU halted (active-high).
REQ-012 pause_frames  out  FW  count of vblank rising edges while halted.

Function
REQ-013 The block SHALL implement four states: RUN, DRAIN, HALTED, RESUME.
REQ-014 In RUN, DRAIN and RESUME, cpu_ce_out SHALL equal cpu_ce_in combinationally; in HALTED, cpu_ce_out SHALL be 0.
REQ-015 RUN -> DRAIN SHALL occur on the first clk_sys edge at which pause_cpu=1.
REQ-016 In DRAIN, a cycle with cpu_ce_in=1 and cpu_bus_idle=1 SHALL pass that pulse and then transition to HALTED on the same clock edge.
REQ-017 In DRAIN, an 8-bit counter SHALL count forwarded cpu_ce_in pulses; when the count reaches DRAIN_TIMEOUT, the block SHALL force HALTED and set a sticky timeout flag (internal, observable in simulation).
REQ-018 In DRAIN, pause_cpu=0 SHALL return the block to RUN and clear the drain counter; this takes priority over REQ-016/REQ-017 in the same cycle.
REQ-019 pause_ack SHALL be a registered output equal to 1 exactly while the state is HALTED, i.e. it rises one cycle after the HALTED-entry edge.
REQ-020 In HALTED, pause_cpu=0 SHALL move to RESUME when SYNC_RESUME=1, or to RUN when SYNC_RESUME=0.
REQ-021 In RESUME, the CPU SHALL stay gated off (cpu_ce_out=0) until a vblank rising edge, then move to RUN; pause_cpu=1 in RESUME SHALL return to HALTED. Note: this overrides REQ-014 for RESUME.
REQ-022 A vblank rising edge SHALL be detected as vblank=1 with the previous registered vblank=0; a vblank already high on entry to RESUME SHALL NOT count as an edge.
REQ-023 pause_frames SHALL clear to 0 on entry to HALTED, increment on each vblank rising edge while in HALTED or RESUME, saturate at all-ones, and hold its value in RUN.
REQ-024 If pause_cpu and cpu_ce_in/cpu_bus_idle change in the same cycle, state decisions SHALL use the sampled values of that cycle only; no combinational path from pause_cpu to pause_ack is allowed.

Reset
REQ-025 Asserting reset SHALL asynchronously force state RUN, pause_ack=0, pause_frames=0, drain counter=0, timeout flag=0, vblank history=0.
REQ-026 Reset asserted in DRAIN, HALTED or RESUME SHALL abandon the operation; after release, cpu_ce_out follows cpu_ce_in immediately if pause_cpu=0.

Structure
REQ-027 The state enumeration, the DRAIN counter width (8) and the default parameter values SHALL live in the shared package cpu_pause_pkg.
REQ-028 Vblank rising-edge detection SHALL be a single sub-module, pause_edge_det (clk_sys, reset, in, rise), reusable by other cores.

Verification
REQ-029 pause_cpu=1 with cpu_bus_idle=1 on the 3rd ce pulse -> exactly 3 pulses are forwarded, pause_ack=1 one cycle after, and cpu_ce_out=0 thereafter.
REQ-030 pause_cpu=1 with cpu_bus_idle held 0 and DRAIN_TIMEOUT=4 -> exactly 4 pulses are forwarded, then HALTED, and the timeout flag is set.
REQ-031 HALTED across 5 vblank pulses -> pause_frames=5; with FW=3 and 9 pulses -> pause_frames=7.
REQ-032 With SYNC_RESUME=1, pause_cpu dropped mid-frame -> cpu_ce_out stays 0 until the next vblank rise, then follows cpu_ce_in; pause_cpu re-raised before that vblank -> back to HALTED with pause_ack=1.
REQ-033 pause_cpu pulsed for 2 cycles with no idle boundary -> DRAIN then RUN, pause_ack never asserts, and no ce pulse is lost.
REQ-034 reset asserted asynchronously in HALTED -> pause_ack=0 and pause_frames=0 with no clock edge; after release with pause_cpu=0, cpu_ce_out equals cpu_ce_in.

Source files
------------

// File: rtl/cpu_pause_pkg.sv
// Shared definitions for the CPU pause controller: state encoding,
// drain-counter width and default parameter values.
package cpu_pause_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } pause_state_e;

    localparam int DRAIN_CNT_W       = 8;
    localparam int DEF_DRAIN_TIMEOUT = 64;
    localparam int DEF_SYNC_RESUME   = 1;
    localparam int DEF_FW            = 16;

endpackage

// File: rtl/pause_edge_det.sv
// Rising-edge detector: one registered history bit, rise is combinational.
module pause_edge_det (
    input  logic clk_sys,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= in;
    end

    assign rise = in & ~r_prev;

endmodule

// File: rtl/cpu_pause_ctrl.sv
// CPU pause controller: drains the CPU to a bus-idle boundary before gating its
// clock enable, optionally resumes on vblank, and counts frames spent paused.
module cpu_pause_ctrl
    import cpu_pause_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int SYNC_RESUME   = DEF_SYNC_RESUME,
    parameter int FW            = DEF_FW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          pause_cpu,
    input  logic          cpu_ce_in,
    input  logic          cpu_bus_idle,
    input  logic          vblank,
    output logic          cpu_ce_out,
    output logic          pause_ack,
    output logic [FW-1:0] pause_frames
);

    localparam logic [DRAIN_CNT_W-1:0] TIMEOUT_L = DRAIN_CNT_W'(DRAIN_TIMEOUT);

    pause_state_e           r_state, w_state_nxt;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt, w_cnt_inc;
    logic                   r_timeout, w_timeout_set;
    logic                   r_ack;
    logic [FW-1:0]          r_frames;
    logic                   w_vb_rise, w_enter_halt, w_in_pause;

    pause_edge_det u_vb_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .in      (vblank),
        .rise    (w_vb_rise)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = '0;
        w_timeout_set   = 1'b0;
        cpu_ce_out      = 1'b0;
        w_cnt_inc       = r_drain_cnt + DRAIN_CNT_W'(cpu_ce_in);
        case (r_state)
            ST_RUN: begin
                cpu_ce_out = cpu_ce_in;
                if (pause_cpu) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                cpu_ce_out      = cpu_ce_in;
                w_drain_cnt_nxt = w_cnt_inc;
                // A withdrawn request wins over both halt conditions.
                if (!pause_cpu) begin
                    w_state_nxt     = ST_RUN;
                    w_drain_cnt_nxt = '0;
                end else if (cpu_ce_in && cpu_bus_idle) begin
                    w_state_nxt     = ST_HALTED;
                    w_drain_cnt_nxt = '0;
                end else if (w_cnt_inc == TIMEOUT_L) begin
                    w_state_nxt     = ST_HALTED;
                    w_drain_cnt_nxt = '0;
                    w_timeout_set   = 1'b1;
                end
            end
            ST_HALTED: begin
                if (!pause_cpu) w_state_nxt = (SYNC_RESUME != 0) ? ST_RESUME : ST_RUN;
            end
            ST_RESUME: begin
                if (pause_cpu)      w_state_nxt = ST_HALTED;
                else if (w_vb_rise) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_enter_halt = (w_state_nxt == ST_HALTED) && (r_state != ST_HALTED);
    assign w_in_pause   = (r_state == ST_HALTED) || (r_state == ST_RESUME);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
            r_ack       <= 1'b0;
            r_frames    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_timeout   <= r_timeout | w_timeout_set;
            r_ack       <= (w_state_nxt == ST_HALTED);
            if (w_enter_halt)
                r_frames <= '0;
            else if (w_in_pause && w_vb_rise && (r_frames != {FW{1'b1}}))
                r_frames <= r_frames + FW'(1);
        end
    end

    assign pause_ack    = r_ack;
    assign pause_frames = r_frames;

endmodule

// File: tb/tb_cpu_pause_ctrl.sv
// Bench for cpu_pause_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the pause rules.
module tb_cpu_pause_ctrl;

    localparam int TO   = 4;
    localparam int FW   = 3;
    localparam int FMAX = (1 << FW) - 1;

    localparam int M_RUN = 0, M_DRN = 1, M_HLT = 2, M_RES = 3;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          pause_cpu, cpu_ce_in, cpu_bus_idle, vblank;
    logic          cpu_ce_out, pause_ack;
    logic [FW-1:0] pause_frames;

    int n_cmp = 0, n_bad = 0;
    int n_fwd, n_ack;
    bit chk_en = 1'b0;

    int m_mode, m_fwd, m_frames;
    bit m_to, m_prev_vb;

    cpu_pause_ctrl #(.DRAIN_TIMEOUT(TO), .SYNC_RESUME(1), .FW(FW)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .pause_cpu    (pause_cpu),
        .cpu_ce_in    (cpu_ce_in),
        .cpu_bus_idle (cpu_bus_idle),
        .vblank       (vblank),
        .cpu_ce_out   (cpu_ce_out),
        .pause_ack    (pause_ack),
        .pause_frames (pause_frames)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what mode the CPU is in, how many pulses went out
    // since the pause request, and how many frames have passed while paused.
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_mode <= M_RUN; m_fwd <= 0; m_frames <= 0; m_to <= 1'b0; m_prev_vb <= 1'b0;
        end else begin
            automatic bit rise   = vblank && !m_prev_vb;
            automatic int mode   = m_mode;
            automatic int fwd    = m_fwd;
            automatic int frames = m_frames;
            automatic bit to     = m_to;
            if ((mode == M_HLT || mode == M_RES) && rise && frames < FMAX) frames++;
            case (mode)
                M_RUN: if (pause_cpu) begin mode = M_DRN; fwd = 0; end
                M_DRN: begin
                    if (!pause_cpu) mode = M_RUN;
                    else begin
                        fwd += int'(cpu_ce_in);
                        if (cpu_ce_in && cpu_bus_idle) begin
                            mode = M_HLT; frames = 0;
                        end else if (fwd == TO) begin
                            mode = M_HLT; frames = 0; to = 1'b1;
                        end
                    end
                end
                M_HLT: if (!pause_cpu) mode = M_RES;
                default: begin
                    if (pause_cpu) begin mode = M_HLT; frames = 0; end
                    else if (rise) mode = M_RUN;
                end
            endcase
            m_mode <= mode; m_fwd <= fwd; m_frames <= frames; m_to <= to;
            m_prev_vb <= vblank;
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("ce_out", int'(cpu_ce_out),
                  (m_mode == M_RUN || m_mode == M_DRN) ? int'(cpu_ce_in) : 0);
            check("pause_ack", int'(pause_ack), int'(m_mode == M_HLT));
            check("pause_frames", int'(pause_frames), m_frames);
            check("timeout_flag", int'(dut.r_timeout), int'(m_to));
        end
    end

    task automatic drv(input bit p, input bit ce, input bit idle, input bit vb);
        @(posedge clk_sys);
        #1;
        pause_cpu = p; cpu_ce_in = ce; cpu_bus_idle = idle; vblank = vb;
        @(negedge clk_sys);
        n_fwd += int'(cpu_ce_out);
        n_ack += int'(pause_ack);
    endtask

    initial begin
        reset = 1'b1; pause_cpu = 1'b0; cpu_ce_in = 1'b0; cpu_bus_idle = 1'b0; vblank = 1'b0;
        n_fwd = 0; n_ack = 0;
        repeat (3) @(negedge clk_sys);
        check("rst_ack", int'(pause_ack), 0);
        check("rst_frames", int'(pause_frames), 0);
        check("rst_timeout", int'(dut.r_timeout), 0);
        @(posedge clk_sys); #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) drv(0, 1, 0, 0);

        // Idle boundary on the 3rd pulse after the request.
        n_fwd = 0;
        drv(1, 0, 0, 0); drv(1, 1, 0, 0); drv(1, 0, 0, 0);
        drv(1, 1, 0, 0); drv(1, 0, 0, 0); drv(1, 1, 1, 0);
        check("drain_ack_low_on_last", int'(pause_ack), 0);
        drv(1, 1, 0, 0);
        check("drain_ack_next", int'(pause_ack), 1);
        repeat (3) drv(1, 1, 0, 0);
        check("drain_fwd", n_fwd, 3);
        check("drain_no_timeout", int'(dut.r_timeout), 0);

        // Frames counted while halted, saturating at 7.
        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 0, 1); drv(1, 0, 0, 0); drv(1, 0, 0, 0);
            if (i == 4) check("frames_5", int'(pause_frames), 5);
        end
        check("frames_sat", int'(pause_frames), 7);

        // Asynchronous reset while halted.
        #1 reset = 1'b1;
        #1;
        check("async_rst_ack", int'(pause_ack), 0);
        check("async_rst_frames", int'(pause_frames), 0);
        @(posedge clk_sys); #1;
        reset = 1'b0; pause_cpu = 1'b0; cpu_ce_in = 1'b1;
        @(negedge clk_sys);
        check("post_rst_ce", int'(cpu_ce_out), 1);

        // Synchronised resume, then re-pause before vblank.
        drv(1, 1, 1, 0); drv(1, 1, 1, 0); drv(1, 0, 0, 0);
        n_fwd = 0;
        repeat (4) drv(0, 1, 0, 0);
        check("resume_gated", n_fwd, 0);
        drv(0, 1, 0, 1);
        check("resume_rise_cycle", int'(cpu_ce_out), 0);
        drv(0, 1, 0, 1);
        check("resume_run", int'(cpu_ce_out), 1);
        drv(0, 1, 0, 0);
        drv(1, 1, 1, 0); drv(1, 1, 1, 0); drv(1, 1, 0, 0);
        drv(0, 1, 0, 0); drv(0, 1, 0, 0); drv(1, 1, 0, 0); drv(1, 1, 0, 0);
        check("repause_ack", int'(pause_ack), 1);
        drv(0, 0, 0, 0); drv(0, 0, 0, 1); drv(0, 0, 0, 0);

        // Short pause pulse with no idle boundary: nothing lost, no ack.
        n_fwd = 0; n_ack = 0;
        drv(1, 1, 0, 0); drv(1, 1, 0, 0);
        repeat (3) drv(0, 1, 0, 0);
        check("short_pause_fwd", n_fwd, 5);
        check("short_pause_ack", n_ack, 0);

        // Drain timeout with the bus never idle.
        n_fwd = 0;
        drv(1, 0, 0, 0);
        repeat (8) drv(1, 1, 0, 0);
        check("timeout_fwd", n_fwd, TO);
        check("timeout_flag_set", int'(dut.r_timeout), 1);
        check("timeout_ack", int'(pause_ack), 1);

        // Randomized traffic.
        begin
            bit p = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 11) == 0) p = ~p;
                drv(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 399) == 0) begin
                    #2 reset = 1'b1;
                    #2 reset = 1'b0;
                end
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
